// File: rtl/pdm_rx_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pdm_rx_pkg
// Description : Shared constants and helper functions for the PDM microphone
//               receive path.
// Revision    : 1.0 - initial release
// ============================================================================
package pdm_rx_pkg;

    localparam int DCB_SHIFT = 8;

    // Accumulator width: one bit for the +/-1 input sign plus CIC growth plus guard.
    function automatic int acc_w(input int order, input int dlog2);
        return order * dlog2 + 2;
    endfunction

    function automatic logic signed [63:0] sat(input logic signed [63:0] value, input int width);
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (width - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (width - 1));
        if (value > hi) begin
            return hi;
        end
        if (value < lo) begin
            return lo;
        end
        return value;
    endfunction

endpackage
`default_nettype wire

// File: rtl/pdm_clkgen.sv
`default_nettype none
// ============================================================================
// Module      : pdm_clkgen
// Description : Divides clk down to the PDM microphone bit clock and flags the
//               cycle that drives pdm_clk high-to-low.
// Revision    : 1.0 - initial release
// ============================================================================
module pdm_clkgen #(
    parameter int CLK_HALF = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    output logic pdm_clk,
    output logic bit_stb
);

    localparam int CW = $clog2(CLK_HALF);

    logic [CW-1:0] div_q;
    logic [CW-1:0] div_d;
    logic          pdm_clk_q;
    logic          pdm_clk_d;
    logic          w_wrap;

    always_comb begin
        w_wrap    = (div_q == CW'(CLK_HALF - 1));
        div_d     = w_wrap ? '0 : div_q + CW'(1);
        pdm_clk_d = w_wrap ? ~pdm_clk_q : pdm_clk_q;
    end

    always_ff @(posedge clk) begin
        if (!rst_n || !en) begin
            div_q     <= '0;
            pdm_clk_q <= 1'b0;
        end else begin
            div_q     <= div_d;
            pdm_clk_q <= pdm_clk_d;
        end
    end

    assign pdm_clk = pdm_clk_q;
    assign bit_stb = en && w_wrap && pdm_clk_q;

endmodule
`default_nettype wire

// File: rtl/pdm_mic_rx.sv
`default_nettype none
// ============================================================================
// Module      : pdm_mic_rx
// Description : PDM microphone receiver: bit-clock generation, input sync,
//               ORDER-stage CIC decimator and valid/ready PCM output.
//               Define PDM_DCBLOCK_EN to insert a one-pole DC blocker.
// Revision    : 1.0 - initial release
// ============================================================================
module pdm_mic_rx
    import pdm_rx_pkg::*;
#(
    parameter int CLK_HALF   = 8,
    parameter int ORDER      = 3,
    parameter int DECIM_LOG2 = 6,
    parameter int OUT_W      = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    en,
    output logic                    pdm_clk,
    input  logic                    pdm_in,
    output logic signed [OUT_W-1:0] pcm_out,
    output logic                    pcm_valid,
    input  logic                    pcm_ready,
    output logic                    pcm_overrun
);

    localparam int ACC_W = acc_w(ORDER, DECIM_LOG2);
    localparam int SHIFT = ORDER * DECIM_LOG2 + 1 - OUT_W;

    logic                    w_bit_stb;
    logic                    sync1_q;
    logic                    sync2_q;
    logic                    dec_stb_q;
    logic [DECIM_LOG2-1:0]   dcnt_q;
    logic signed [ACC_W-1:0] w_x;
    logic signed [ACC_W-1:0] w_comb_out;
    logic signed [ACC_W-1:0] w_scaled;
    logic signed [63:0]      w_pre;
    logic signed [OUT_W-1:0] w_sat;
    logic                    w_new;
    logic signed [OUT_W-1:0] pcm_out_q;
    logic                    pcm_valid_q;
    logic                    pcm_overrun_q;

    pdm_clkgen #(
        .CLK_HALF (CLK_HALF)
    ) u_clkgen (
        .clk     (clk),
        .rst_n   (rst_n),
        .en      (en),
        .pdm_clk (pdm_clk),
        .bit_stb (w_bit_stb)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            sync1_q <= pdm_in;
            sync2_q <= sync1_q;
        end
    end

    assign w_x = sync2_q ? ACC_W'(1) : '1;

    // Integrators cascade within one cycle: each stage adds its predecessor's new value.
    for (genvar k = 0; k < ORDER; k++) begin : g_integ
        logic signed [ACC_W-1:0] acc_q;
        logic signed [ACC_W-1:0] acc_d;
        if (k == 0) begin : g_first
            assign acc_d = acc_q + w_x;
        end else begin : g_rest
            assign acc_d = acc_q + g_integ[k-1].acc_d;
        end
        always_ff @(posedge clk) begin
            if (!rst_n || !en) begin
                acc_q <= '0;
            end else if (w_bit_stb) begin
                acc_q <= acc_d;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n || !en) begin
            dcnt_q    <= '0;
            dec_stb_q <= 1'b0;
        end else begin
            dec_stb_q <= w_bit_stb && (dcnt_q == '1);
            if (w_bit_stb) begin
                dcnt_q <= dcnt_q + DECIM_LOG2'(1);
            end
        end
    end

    for (genvar k = 0; k < ORDER; k++) begin : g_comb
        logic signed [ACC_W-1:0] dly_q;
        logic signed [ACC_W-1:0] w_in;
        logic signed [ACC_W-1:0] w_out;
        if (k == 0) begin : g_first
            assign w_in = g_integ[ORDER-1].acc_q;
        end else begin : g_rest
            assign w_in = g_comb[k-1].w_out;
        end
        assign w_out = w_in - dly_q;
        always_ff @(posedge clk) begin
            if (!rst_n || !en) begin
                dly_q <= '0;
            end else if (dec_stb_q) begin
                dly_q <= w_in;
            end
        end
    end

    assign w_comb_out = g_comb[ORDER-1].w_out;
    assign w_scaled   = w_comb_out >>> SHIFT;

`ifdef PDM_DCBLOCK_EN
    localparam int DW = OUT_W + 2;

    logic signed [DW-1:0] s_prev_q;
    logic signed [DW-1:0] y_q;
    logic signed [DW-1:0] w_s;
    logic signed [DW-1:0] w_y;
    logic                 dcb_stb_q;

    assign w_s = DW'(w_scaled);
    assign w_y = w_s - s_prev_q + y_q - (y_q >>> DCB_SHIFT);

    always_ff @(posedge clk) begin
        if (!rst_n || !en) begin
            s_prev_q  <= '0;
            y_q       <= '0;
            dcb_stb_q <= 1'b0;
        end else begin
            dcb_stb_q <= dec_stb_q;
            if (dec_stb_q) begin
                s_prev_q <= w_s;
                y_q      <= w_y;
            end
        end
    end

    assign w_new = dcb_stb_q;
    assign w_pre = 64'(y_q);
`else
    assign w_new = dec_stb_q;
    assign w_pre = 64'(w_scaled);
`endif

    assign w_sat = OUT_W'(sat(w_pre, OUT_W));

    // A new sample always wins; it only counts as an overrun if the old one was not taken.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pcm_out_q     <= '0;
            pcm_valid_q   <= 1'b0;
            pcm_overrun_q <= 1'b0;
        end else begin
            pcm_overrun_q <= w_new && pcm_valid_q && !pcm_ready;
            if (w_new) begin
                pcm_out_q   <= w_sat;
                pcm_valid_q <= 1'b1;
            end else if (pcm_ready) begin
                pcm_valid_q <= 1'b0;
            end
        end
    end

    assign pcm_out     = pcm_out_q;
    assign pcm_valid   = pcm_valid_q;
    assign pcm_overrun = pcm_overrun_q;

endmodule
`default_nettype wire
